// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: shared funct3 codes, FSM states, fault causes and access-size decode for the load/store unit
package rv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_ILLEGAL  = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } cause_e;

    // log2 of the access size in bytes; unsigned loads share the low bits of their signed twin
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    // unsigned codes exist only for loads, and double/word-unsigned only on a 64-bit datapath
    function automatic logic f3_legal(input logic [2:0] f3, input logic we, input logic x64);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_D:             return x64;
            F3_BU, F3_HU:     return !we;
            F3_WU:            return !we && x64;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// rv_lsu_if: req/ack data bus between the load/store unit (master) and data memory (slave)
interface rv_lsu_if #(parameter int XLEN = 32);

    logic              bus_req;
    logic              bus_we;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN/8-1:0] bus_be;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_ack;
    logic [XLEN-1:0]   bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: byte-lane steering for stores and right-shift plus sign/zero extension for loads
module rv_lsu_align
    import rv_lsu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OW   = $clog2(NB)
) (
    input  logic [2:0]      st_fn3,
    input  logic [OW-1:0]   st_off,
    input  logic [XLEN-1:0] st_data,
    output logic [NB-1:0]   be,
    output logic [XLEN-1:0] st_wdata,
    input  logic [2:0]      ld_fn3,
    input  logic [OW-1:0]   ld_off,
    input  logic [XLEN-1:0] ld_raw,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] sh_w;
    logic [XLEN-1:0] sh_r;

    // store side: enable the lanes covered by the access, shift data into them, zero the rest
    always_comb begin
        be       = '0;
        st_wdata = '0;
        sh_w     = st_data << {st_off, 3'b000};
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(st_off)) && (i < int'(st_off) + (1 << int'(f3_size(st_fn3))));
            st_wdata[8*i +: 8] = be[i] ? sh_w[8*i +: 8] : 8'h00;
        end
    end

    // load side: bring the addressed lanes down to bit 0, then extend to XLEN
    always_comb begin
        sh_r    = ld_raw >> {ld_off, 3'b000};
        ld_data = sh_r;
        case (ld_fn3)
            F3_B:    ld_data = XLEN'($signed(sh_r[7:0]));
            F3_H:    ld_data = XLEN'($signed(sh_r[15:0]));
            F3_W:    ld_data = XLEN'($signed(sh_r[31:0]));
            F3_BU:   ld_data = XLEN'(sh_r[7:0]);
            F3_HU:   ld_data = XLEN'(sh_r[15:0]);
            F3_WU:   ld_data = XLEN'(sh_r[31:0]);
            default: ld_data = sh_r;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit with req/ack bus, core stall and fault reporting; define LSU_TIMEOUT_EN to abort stuck bus cycles
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      fn3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            err,
    output logic [1:0]      err_cause,
    rv_lsu_if.master        bus
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    if ((XLEN != 32 && XLEN != 64) || TIMEOUT_CYC < 1) begin : g_param_check
        $error("rv_lsu: XLEN must be 32 or 64 and TIMEOUT_CYC must be positive");
    end

    state_e          state_q, state_d;
    logic [2:0]      fn3_q, fn3_d;
    logic [OW-1:0]   off_q, off_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [NB-1:0]   bus_be_q, bus_be_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    cause_e          cause_q, cause_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]   tmo_q, tmo_d;
`endif

    logic            req;
    logic            mis;
    logic [3:0]      sz_mask;
    logic [NB-1:0]   be_c;
    logic [XLEN-1:0] wd_c;
    logic [XLEN-1:0] ld_c;

    rv_lsu_align #(.XLEN(XLEN)) u_align (
        .st_fn3   (fn3),
        .st_off   (addr[OW-1:0]),
        .st_data  (wdata),
        .be       (be_c),
        .st_wdata (wd_c),
        .ld_fn3   (fn3_q),
        .ld_off   (off_q),
        .ld_raw   (bus.bus_rdata),
        .ld_data  (ld_c)
    );

    assign req     = mem_read || mem_write;
    assign sz_mask = (4'd1 << f3_size(fn3)) - 4'd1;
    assign mis     = |(addr[OW-1:0] & sz_mask[OW-1:0]);

    // the core must hold while a request is being accepted or the bus is busy; RESP lets it advance once
    assign stall = (state_q == IDLE && req) || state_q == BUS;

    // next-state: accept and classify in IDLE, wait for ack in BUS, pulse done in RESP
    always_comb begin
        state_d     = state_q;
        fn3_d       = fn3_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cause_d     = CAUSE_NONE;
        rdata_d     = '0;
`ifdef LSU_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    fn3_d = fn3;
                    off_d = addr[OW-1:0];
                    if (!f3_legal(fn3, mem_write, XLEN == 64) || (mem_read && mem_write)) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (mis) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d     = BUS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[XLEN-1:OW], {OW{1'b0}}};
                        bus_be_d    = be_c;
                        bus_wdata_d = wd_c;
`ifdef LSU_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end
                end
            end
            BUS: begin
                if (bus.bus_ack) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = bus_we_q ? '0 : ld_c;
                end
`ifdef LSU_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(TIMEOUT_CYC)) begin
                        state_d   = RESP;
                        bus_req_d = 1'b0;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        cause_d   = CAUSE_TIMEOUT;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset drops any bus cycle in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fn3_q       <= '0;
            off_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cause_q     <= CAUSE_NONE;
            rdata_q     <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fn3_q       <= fn3_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cause_q     <= cause_d;
            rdata_q     <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign done          = done_q;
    assign err           = err_q;
    assign err_cause     = cause_q;
    assign rdata         = rdata_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed checks of rv_lsu at XLEN=32 and XLEN=64 (TIMEOUT_CYC=4); LSU_TIMEOUT_EN selects the timeout scenario
module tb_rv_lsu;
    import rv_lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       rd, wr;
    logic [1:0][2:0]  f3;
    logic [1:0][63:0] ad, wd;
    logic             stall32, done32, err32, stall64, done64, err64;
    logic [1:0]       cause32, cause64;
    logic [31:0]      rdata32;
    logic [63:0]      rdata64;

    rv_lsu_if #(.XLEN(32)) if32();
    rv_lsu_if #(.XLEN(64)) if64();

    rv_lsu #(.XLEN(32), .TIMEOUT_CYC(4)) dut32 (
        .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]), .fn3(f3[0]),
        .addr(ad[0][31:0]), .wdata(wd[0][31:0]), .stall(stall32), .done(done32),
        .rdata(rdata32), .err(err32), .err_cause(cause32), .bus(if32)
    );

    rv_lsu #(.XLEN(64), .TIMEOUT_CYC(4)) dut64 (
        .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]), .fn3(f3[1]),
        .addr(ad[1]), .wdata(wd[1]), .stall(stall64), .done(done64),
        .rdata(rdata64), .err(err64), .err_cause(cause64), .bus(if64)
    );

    int n_chk = 0;
    int n_fail = 0;

    int          t_done_c, t_done_n, t_stalls, t_req_cyc;
    logic [63:0] t_r, t_addr, t_wdata;
    logic [7:0]  t_be;
    logic        t_e, t_we;
    logic [1:0]  t_cause;

    // drives one access for up to 24 cycles (cycle 0 = request), acking on cycle ack_c, and records what it saw
    task automatic run(input bit w, input logic r_, input logic w_, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] d, input logic [63:0] rdat, input int ack_c);
        bit seen = 1'b0;
        rd[w] = r_; wr[w] = w_; f3[w] = f; ad[w] = a; wd[w] = d;
        t_done_c = -1; t_done_n = 0; t_stalls = 0; t_req_cyc = 0;
        t_r = '0; t_addr = '0; t_wdata = '0; t_be = '0; t_e = 1'b0; t_we = 1'b0; t_cause = '0;
        for (int c = 0; c < 24; c++) begin
            if (w) begin if64.bus_ack = (c == ack_c); if64.bus_rdata = rdat; end
            else begin if32.bus_ack = (c == ack_c); if32.bus_rdata = rdat[31:0]; end
            @(negedge clk);
            if (w ? stall64 : stall32) t_stalls++;
            if (w ? if64.bus_req : if32.bus_req) begin
                t_req_cyc++;
                if (!seen) begin
                    seen    = 1'b1;
                    t_we    = w ? if64.bus_we : if32.bus_we;
                    t_be    = w ? if64.bus_be : {4'h0, if32.bus_be};
                    t_addr  = w ? if64.bus_addr : {32'h0, if32.bus_addr};
                    t_wdata = w ? if64.bus_wdata : {32'h0, if32.bus_wdata};
                end
            end
            if (w ? done64 : done32) begin
                t_done_n++;
                if (t_done_c < 0) begin
                    t_done_c = c;
                    t_r      = w ? rdata64 : {32'h0, rdata32};
                    t_e      = w ? err64 : err32;
                    t_cause  = w ? cause64 : cause32;
                end
            end
            @(posedge clk); #1;
            if (t_done_c >= 0) begin rd[w] = 1'b0; wr[w] = 1'b0; end
        end
        if32.bus_ack = 1'b0;
        if64.bus_ack = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_chk++; if ({done32, err32, cause32, rdata32} !== '0) begin n_fail++; $display("FAIL reset_core32: got %h required 0", {done32, err32, cause32, rdata32}); end
        n_chk++; if ({if32.bus_req, if32.bus_we, if32.bus_be, if32.bus_addr, if32.bus_wdata} !== '0) begin n_fail++; $display("FAIL reset_bus32: bus_req=%b be=%h addr=%h required all 0", if32.bus_req, if32.bus_be, if32.bus_addr); end
        n_chk++; if ({done64, err64, cause64, rdata64, if64.bus_req, if64.bus_be} !== '0) begin n_fail++; $display("FAIL reset_64: done=%b req=%b rdata=%h required all 0", done64, if64.bus_req, rdata64); end
        n_chk++; if ({stall32, stall64} !== 2'b00) begin n_fail++; $display("FAIL reset_stall: got %b required 00", {stall32, stall64}); end
    endtask

    task automatic test_lw;
        run(1'b0, 1'b1, 1'b0, F3_W, 64'h100, 64'h0, 64'hDEADBEEF, 3);
        n_chk++; if (t_done_c !== 4) begin n_fail++; $display("FAIL lw_done_cycle: got %0d required 4", t_done_c); end
        n_chk++; if (t_done_n !== 1) begin n_fail++; $display("FAIL lw_done_count: got %0d required 1", t_done_n); end
        n_chk++; if (t_stalls !== 4) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d required 4", t_stalls); end
        n_chk++; if (t_req_cyc !== 3) begin n_fail++; $display("FAIL lw_req_cycles: got %0d required 3", t_req_cyc); end
        n_chk++; if (t_be !== 8'h0F) begin n_fail++; $display("FAIL lw_be: got %h required 0f", t_be); end
        n_chk++; if (t_addr !== 64'h100 || t_we !== 1'b0) begin n_fail++; $display("FAIL lw_addr_we: got %h/%b required 100/0", t_addr, t_we); end
        n_chk++; if (t_r !== 64'hDEADBEEF || t_e !== 1'b0) begin n_fail++; $display("FAIL lw_rdata: got %h err %b required deadbeef err 0", t_r, t_e); end
    endtask

    task automatic test_byte_half_loads;
        run(1'b0, 1'b1, 1'b0, F3_B, 64'h103, 64'h0, 64'h80123456, 1);
        n_chk++; if (t_be !== 8'h08 || t_addr !== 64'h100) begin n_fail++; $display("FAIL lb_be_addr: got %h/%h required 08/100", t_be, t_addr); end
        n_chk++; if (t_done_c !== 2) begin n_fail++; $display("FAIL lb_done_cycle: got %0d required 2", t_done_c); end
        n_chk++; if (t_r !== 64'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h required ffffff80", t_r); end
        run(1'b0, 1'b1, 1'b0, F3_BU, 64'h103, 64'h0, 64'h80123456, 2);
        n_chk++; if (t_r !== 64'h00000080) begin n_fail++; $display("FAIL lbu_rdata: got %h required 00000080", t_r); end
        run(1'b0, 1'b1, 1'b0, F3_H, 64'h102, 64'h0, 64'h80123456, 1);
        n_chk++; if (t_r !== 64'hFFFF8012 || t_be !== 8'h0C) begin n_fail++; $display("FAIL lh_rdata: got %h be %h required ffff8012 be 0c", t_r, t_be); end
        run(1'b0, 1'b1, 1'b0, F3_HU, 64'h102, 64'h0, 64'h80123456, 1);
        n_chk++; if (t_r !== 64'h00008012) begin n_fail++; $display("FAIL lhu_rdata: got %h required 00008012", t_r); end
    endtask

    task automatic test_stores;
        run(1'b0, 1'b0, 1'b1, F3_H, 64'h102, 64'h0000ABCD, 64'hFFFFFFFF, 1);
        n_chk++; if (t_we !== 1'b1 || t_be !== 8'h0C) begin n_fail++; $display("FAIL sh_we_be: got %b/%h required 1/0c", t_we, t_be); end
        n_chk++; if (t_wdata !== 64'hABCD0000 || t_addr !== 64'h100) begin n_fail++; $display("FAIL sh_wdata_addr: got %h/%h required abcd0000/100", t_wdata, t_addr); end
        n_chk++; if (t_done_c !== 2 || t_r !== 64'h0 || t_e !== 1'b0) begin n_fail++; $display("FAIL sh_done: cycle %0d rdata %h err %b required 2/0/0", t_done_c, t_r, t_e); end
        run(1'b0, 1'b0, 1'b1, F3_B, 64'h101, 64'h12345678, 64'h0, 2);
        n_chk++; if (t_be !== 8'h02 || t_wdata !== 64'h00007800) begin n_fail++; $display("FAIL sb_lanes: got be %h wdata %h required 02/00007800", t_be, t_wdata); end
    endtask

    task automatic test_faults;
        run(1'b0, 1'b1, 1'b0, F3_W, 64'h102, 64'h0, 64'h0, 1);
        n_chk++; if (t_req_cyc !== 0 || t_done_c !== 1) begin n_fail++; $display("FAIL lw_mis_timing: req %0d done %0d required 0/1", t_req_cyc, t_done_c); end
        n_chk++; if (t_e !== 1'b1 || t_cause !== 2'd1 || t_r !== 64'h0) begin n_fail++; $display("FAIL lw_mis_cause: err %b cause %0d rdata %h required 1/1/0", t_e, t_cause, t_r); end
        n_chk++; if (t_stalls !== 1) begin n_fail++; $display("FAIL lw_mis_stall: got %0d required 1", t_stalls); end
        run(1'b0, 1'b1, 1'b0, F3_H, 64'h101, 64'h0, 64'h0, 1);
        n_chk++; if (t_cause !== 2'd1 || t_req_cyc !== 0) begin n_fail++; $display("FAIL lh_mis: cause %0d req %0d required 1/0", t_cause, t_req_cyc); end
        run(1'b0, 1'b1, 1'b0, F3_D, 64'h100, 64'h0, 64'h0, 1);
        n_chk++; if (t_e !== 1'b1 || t_cause !== 2'd2 || t_done_c !== 1) begin n_fail++; $display("FAIL ld32_illegal: err %b cause %0d done %0d required 1/2/1", t_e, t_cause, t_done_c); end
        run(1'b0, 1'b1, 1'b0, 3'b111, 64'h100, 64'h0, 64'h0, 1);
        n_chk++; if (t_cause !== 2'd2 || t_req_cyc !== 0) begin n_fail++; $display("FAIL f3_111_illegal: cause %0d req %0d required 2/0", t_cause, t_req_cyc); end
        run(1'b0, 1'b1, 1'b1, F3_W, 64'h100, 64'h0, 64'h0, 1);
        n_chk++; if (t_cause !== 2'd2 || t_req_cyc !== 0) begin n_fail++; $display("FAIL rdwr_illegal: cause %0d req %0d required 2/0", t_cause, t_req_cyc); end
        run(1'b0, 1'b0, 1'b1, F3_BU, 64'h100, 64'h0, 64'h0, 1);
        n_chk++; if (t_cause !== 2'd2) begin n_fail++; $display("FAIL store_unsigned_illegal: cause %0d required 2", t_cause); end
        run(1'b1, 1'b0, 1'b1, F3_D, 64'h4, 64'h0, 64'h0, 1);
        n_chk++; if (t_cause !== 2'd1 || t_req_cyc !== 0) begin n_fail++; $display("FAIL sd64_mis: cause %0d req %0d required 1/0", t_cause, t_req_cyc); end
    endtask

    task automatic test_reset_in_bus;
        rd[0] = 1'b1; wr[0] = 1'b0; f3[0] = F3_W; ad[0] = 64'h100;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++; if (if32.bus_req !== 1'b1) begin n_fail++; $display("FAIL rib_in_bus: bus_req %b required 1", if32.bus_req); end
        @(posedge clk); #1;
        reset = 1'b1; rd[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; if32.bus_ack = 1'b1; if32.bus_rdata = 32'h12345678;
        @(negedge clk);
        n_chk++; if ({if32.bus_req, done32, stall32} !== 3'b000) begin n_fail++; $display("FAIL rib_after_reset: req/done/stall %b required 000", {if32.bus_req, done32, stall32}); end
        @(posedge clk); #1;
        if32.bus_ack = 1'b0;
        @(negedge clk);
        n_chk++; if ({if32.bus_req, done32, err32, stall32} !== 4'b0000) begin n_fail++; $display("FAIL rib_late_ack: req/done/err/stall %b required 0000", {if32.bus_req, done32, err32, stall32}); end
        @(posedge clk); #1;
        run(1'b0, 1'b1, 1'b0, F3_W, 64'h200, 64'h0, 64'hCAFEF00D, 2);
        n_chk++; if (t_done_c !== 3 || t_done_n !== 1 || t_r !== 64'hCAFEF00D) begin n_fail++; $display("FAIL rib_next_lw: done %0d count %0d rdata %h required 3/1/cafef00d", t_done_c, t_done_n, t_r); end
    endtask

    task automatic test_xlen64;
        run(1'b1, 1'b1, 1'b0, F3_WU, 64'h14, 64'h0, 64'h89ABCDEF_00000000, 1);
        n_chk++; if (t_be !== 8'hF0 || t_addr !== 64'h10) begin n_fail++; $display("FAIL lwu64_be_addr: got %h/%h required f0/10", t_be, t_addr); end
        n_chk++; if (t_r !== 64'h00000000_89ABCDEF) begin n_fail++; $display("FAIL lwu64_rdata: got %h required 0000000089abcdef", t_r); end
        run(1'b1, 1'b1, 1'b0, F3_W, 64'h14, 64'h0, 64'h89ABCDEF_00000000, 1);
        n_chk++; if (t_r !== 64'hFFFFFFFF_89ABCDEF) begin n_fail++; $display("FAIL lw64_rdata: got %h required ffffffff89abcdef", t_r); end
        run(1'b1, 1'b1, 1'b0, F3_D, 64'h8, 64'h0, 64'h11223344_55667788, 2);
        n_chk++; if (t_r !== 64'h11223344_55667788 || t_be !== 8'hFF || t_done_c !== 3) begin n_fail++; $display("FAIL ld64: rdata %h be %h done %0d required 1122334455667788/ff/3", t_r, t_be, t_done_c); end
        run(1'b1, 1'b0, 1'b1, F3_H, 64'h6, 64'h0000_0000_0000_BEEF, 64'h0, 1);
        n_chk++; if (t_be !== 8'hC0 || t_wdata !== 64'hBEEF0000_00000000 || t_addr !== 64'h0) begin n_fail++; $display("FAIL sh64: be %h wdata %h addr %h required c0/beef000000000000/0", t_be, t_wdata, t_addr); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout;
        run(1'b1, 1'b1, 1'b0, F3_D, 64'h40, 64'h0, 64'h0, -1);
        n_chk++; if (t_done_c !== 5 || t_done_n !== 1) begin n_fail++; $display("FAIL timeout_done: cycle %0d count %0d required 5/1", t_done_c, t_done_n); end
        n_chk++; if (t_req_cyc !== 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d required 4", t_req_cyc); end
        n_chk++; if (t_e !== 1'b1 || t_cause !== 2'd3 || t_r !== 64'h0) begin n_fail++; $display("FAIL timeout_cause: err %b cause %0d rdata %h required 1/3/0", t_e, t_cause, t_r); end
    endtask
`else
    task automatic test_timeout;
        run(1'b1, 1'b1, 1'b0, F3_D, 64'h40, 64'h0, 64'h0, -1);
        n_chk++; if (t_done_n !== 0 || t_req_cyc !== 23) begin n_fail++; $display("FAIL no_timeout_wait: done %0d req cycles %0d required 0/23", t_done_n, t_req_cyc); end
        if64.bus_ack = 1'b1; if64.bus_rdata = 64'h01234567_89ABCDEF;
        @(posedge clk); #1;
        if64.bus_ack = 1'b0; rd[1] = 1'b0;
        @(negedge clk);
        n_chk++; if (done64 !== 1'b1 || err64 !== 1'b0 || rdata64 !== 64'h01234567_89ABCDEF) begin n_fail++; $display("FAIL no_timeout_late_ack: done %b err %b rdata %h required 1/0/0123456789abcdef", done64, err64, rdata64); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rd = '0; wr = '0; f3 = '0; ad = '0; wd = '0;
        if32.bus_ack = 1'b0; if32.bus_rdata = '0;
        if64.bus_ack = 1'b0; if64.bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        test_lw;
        test_byte_half_loads;
        test_stores;
        test_faults;
        test_reset_in_bus;
        test_xlen64;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
